// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: owns head/tail/count and per-entry busy/done
// bits, and produces the decode-write, completion-write, commit-read and
// per-entry reset controls for the ROB register file.
module rob_ctrl #(
    parameter int ROBsize  = 32,
    parameter int addrSize = $clog2(ROBsize)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                allocReq_i,
    output logic                allocGrant_o,
    output logic [addrSize-1:0] allocAddr_o,
    input  logic                completeValid_i,
    input  logic [addrSize-1:0] completeAddr_i,
    output logic                completionWriteEn_o,
    input  logic                commitReady_i,
    output logic                commitValid_o,
    output logic [addrSize-1:0] commitAddr_o,
    input  logic                flush_i,
    output logic [ROBsize-1:0]  resets_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [addrSize:0]   count_o
);

    localparam logic [addrSize:0] fullCount = (addrSize+1)'(ROBsize);

    logic [addrSize-1:0] head;
    logic [addrSize-1:0] tail;
    logic [addrSize:0]   count;
    logic [ROBsize-1:0]  busy;
    logic [ROBsize-1:0]  done;
    logic                retire;
    logic                retireHit;

    // Status outputs come from registered state only.
    assign full_o        = (count == fullCount);
    assign empty_o       = (count == '0);
    assign count_o       = count;
    assign allocAddr_o   = tail;
    assign commitAddr_o  = head;
    assign commitValid_o = busy[head] & done[head];

    // Grant/retire/completion qualification; reset and flush suppress all
    // state-changing events. Full blocks allocation even when the head
    // retires this cycle, so alloc and retire never touch the same entry.
    always_comb begin
        allocGrant_o        = allocReq_i & ~full_o & ~flush_i & ~reset_i;
        retire              = commitValid_o & commitReady_i & ~flush_i & ~reset_i;
        retireHit           = retire & (completeAddr_i == head);
        completionWriteEn_o = completeValid_i & busy[completeAddr_i]
                              & ~flush_i & ~reset_i & ~retireHit;
    end

    // Per-entry register-file resets: everything on reset/flush, otherwise
    // only the entry retiring on this edge.
    always_comb begin
        resets_o = '0;
        for (int k = 0; k < ROBsize; k++) begin
            resets_o[k] = reset_i | flush_i | (retire & (head == addrSize'(k)));
        end
    end

    // Pointer, occupancy and per-entry busy/done state.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (allocGrant_o) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + addrSize'(1);
            end
            if (completionWriteEn_o) begin
                done[completeAddr_i] <= 1'b1;
            end
            if (retire) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + addrSize'(1);
            end
            count <= count + (addrSize+1)'(allocGrant_o) - (addrSize+1)'(retire);
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl (ROBsize = 8). Stimulus pushes expected
// per-cycle outputs and expected alloc/commit order; a monitor on the
// falling edge pops and compares.
module tb_rob_ctrl;

    localparam int N = 8;
    localparam int AW = 3;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          allocReq_i = 1'b0;
    logic          allocGrant_o;
    logic [AW-1:0] allocAddr_o;
    logic          completeValid_i = 1'b0;
    logic [AW-1:0] completeAddr_i = '0;
    logic          completionWriteEn_o;
    logic          commitReady_i = 1'b0;
    logic          commitValid_o;
    logic [AW-1:0] commitAddr_o;
    logic          flush_i = 1'b0;
    logic [N-1:0]  resets_o;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   count_o;

    rob_ctrl #(.ROBsize(N)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .allocReq_i          (allocReq_i),
        .allocGrant_o        (allocGrant_o),
        .allocAddr_o         (allocAddr_o),
        .completeValid_i     (completeValid_i),
        .completeAddr_i      (completeAddr_i),
        .completionWriteEn_o (completionWriteEn_o),
        .commitReady_i       (commitReady_i),
        .commitValid_o       (commitValid_o),
        .commitAddr_o        (commitAddr_o),
        .flush_i             (flush_i),
        .resets_o            (resets_o),
        .full_o              (full_o),
        .empty_o             (empty_o),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected outputs for one cycle; -1 means don't care.
    typedef struct {
        string tag;
        int    g, aa, cw, vl, cad, rs, cn;
    } exp_t;

    exp_t chkQ[$];
    int   allocQ[$];
    int   commitQ[$];
    bit   evtOn = 1'b0;
    int   tests = 0;
    int   failed = 0;

    function automatic void cmp(string name, int act, int exp);
        if (exp < 0) return;
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: per-cycle vector checks plus event-driven alloc/commit order.
    initial begin
        exp_t e;
        int   x;
        forever begin
            @(negedge clk_i);
            if (chkQ.size() > 0) begin
                e = chkQ.pop_front();
                cmp({e.tag, ".grant"},     int'(allocGrant_o),        e.g);
                cmp({e.tag, ".allocAddr"}, int'(allocAddr_o),         e.aa);
                cmp({e.tag, ".compWE"},    int'(completionWriteEn_o), e.cw);
                cmp({e.tag, ".commitV"},   int'(commitValid_o),       e.vl);
                cmp({e.tag, ".commitAddr"},int'(commitAddr_o),        e.cad);
                cmp({e.tag, ".resets"},    int'(resets_o),            e.rs);
                cmp({e.tag, ".count"},     int'(count_o),             e.cn);
                if (e.cn >= 0) begin
                    cmp({e.tag, ".full"},  int'(full_o),  int'(e.cn == N));
                    cmp({e.tag, ".empty"}, int'(empty_o), int'(e.cn == 0));
                end
            end
            if (evtOn) begin
                cmp("cntMax", int'(count_o <= N), 1);
                if (allocGrant_o) begin
                    if (allocQ.size() == 0) cmp("allocUnexpected", 1, 0);
                    else begin
                        x = allocQ.pop_front();
                        cmp("allocOrder", int'(allocAddr_o), x);
                    end
                end
                if (commitValid_o && commitReady_i && !flush_i && !reset_i) begin
                    if (commitQ.size() == 0) cmp("commitUnexpected", 1, 0);
                    else begin
                        x = commitQ.pop_front();
                        cmp("commitOrder", int'(commitAddr_o), x);
                        cmp("commitResets", int'(resets_o), 1 << x);
                    end
                end
            end
        end
    end

    task automatic cyc(input string tag, input int req, cv, ca, rdy, fl, rst,
                       input int g, aa, cw, vl, cad, rs, cn);
        exp_t e;
        allocReq_i      = req[0];
        completeValid_i = cv[0];
        completeAddr_i  = AW'(ca);
        commitReady_i   = rdy[0];
        flush_i         = fl[0];
        reset_i         = rst[0];
        e.tag = tag; e.g = g; e.aa = aa; e.cw = cw; e.vl = vl;
        e.cad = cad; e.rs = rs; e.cn = cn;
        chkQ.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int granted, retired, cycles, nextPend;
        int pend[$];
        logic [15:0] pat;

        @(posedge clk_i);
        #1;
        //      tag           req cv ca rdy fl rst   g  aa cw vl cad  rs  cn
        cyc("rst0",          1, 1, 5, 1, 0, 1,    0, -1, 0, -1, -1, 255, -1);
        cyc("rst1",          1, 1, 5, 1, 0, 1,    0,  0, 0,  0,  0, 255,  0);
        cyc("idle",          0, 0, 0, 0, 0, 0,    0,  0, 0,  0,  0,   0,  0);
        for (int i = 0; i < N; i++)
            cyc("fill",      1, 0, 0, 0, 0, 0,    1,  i, 0,  0,  0,   0,  i);
        cyc("ninthReq",      1, 0, 0, 0, 0, 0,    0,  0, 0,  0,  0,   0,  8);
        cyc("flushFull",     1, 0, 0, 0, 1, 0,    0, -1, 0, -1, -1, 255,  8);
        cyc("postFlush",     0, 0, 0, 0, 0, 0,    0,  0, 0,  0,  0,   0,  0);
        // out-of-order completion, in-order retire
        cyc("a0",            1, 0, 0, 0, 0, 0,    1,  0, 0,  0,  0,   0,  0);
        cyc("a1",            1, 0, 0, 0, 0, 0,    1,  1, 0,  0,  0,   0,  1);
        cyc("a2",            1, 0, 0, 0, 0, 0,    1,  2, 0,  0,  0,   0,  2);
        cyc("comp2",         0, 1, 2, 1, 0, 0,    0,  3, 1,  0,  0,   0,  3);
        cyc("comp0",         0, 1, 0, 1, 0, 0,    0,  3, 1,  0,  0,   0,  3);
        cyc("retire0",       0, 0, 0, 1, 0, 0,    0,  3, 0,  1,  0,   1,  3);
        cyc("stallAt1",      0, 0, 0, 1, 0, 0,    0,  3, 0,  0,  1,   0,  2);
        cyc("comp1",         0, 1, 1, 1, 0, 0,    0,  3, 1,  0,  1,   0,  2);
        cyc("retire1Hit",    0, 1, 1, 1, 0, 0,    0,  3, 0,  1,  1,   2,  2);
        cyc("retire2",       0, 0, 0, 1, 0, 0,    0,  3, 0,  1,  2,   4,  1);
        cyc("drained",       0, 0, 0, 1, 0, 0,    0,  3, 0,  0,  3,   0,  0);
        // completion to a non-busy entry
        cyc("nonBusy5",      0, 1, 5, 1, 0, 0,    0,  3, 0,  0,  3,   0,  0);
        cyc("after5",        0, 0, 0, 1, 0, 0,    0,  3, 0,  0,  3,   0,  0);
        // alloc and complete same index in one cycle: completion dropped
        cyc("allocComp3",    1, 1, 3, 1, 0, 0,    1,  3, 0,  0,  3,   0,  0);
        cyc("notDone3",      0, 0, 0, 1, 0, 0,    0,  4, 0,  0,  3,   0,  1);
        cyc("comp3",         0, 1, 3, 0, 0, 0,    0,  4, 1,  0,  3,   0,  1);
        cyc("repeat3",       0, 1, 3, 0, 0, 0,    0,  4, 1,  1,  3,   0,  1);
        cyc("hold3",         0, 0, 0, 0, 0, 0,    0,  4, 0,  1,  3,   0,  1);
        // fill to full behind a done head, then retire while full
        for (int i = 0; i < 7; i++)
            cyc("fill2",     1, 0, 0, 0, 0, 0,    1, (4+i)%8, 0, 1, 3, 0, 1+i);
        cyc("fullRetire",    1, 0, 0, 1, 0, 0,    0,  3, 0,  1,  3,   8,  8);
        cyc("regrant",       1, 0, 0, 0, 0, 0,    1,  3, 0,  0,  4,   0,  7);
        cyc("fullAgain",     0, 0, 0, 0, 0, 0,    0,  4, 0,  0,  4,   0,  8);
        // bring down to 5 in flight, then flush with everything active
        cyc("comp4",         0, 1, 4, 0, 0, 0,    0,  4, 1,  0,  4,   0,  8);
        cyc("comp5",         0, 1, 5, 0, 0, 0,    0,  4, 1,  1,  4,   0,  8);
        cyc("comp6",         0, 1, 6, 0, 0, 0,    0,  4, 1,  1,  4,   0,  8);
        cyc("retire4",       0, 0, 0, 1, 0, 0,    0,  4, 0,  1,  4,  16,  8);
        cyc("retire5",       0, 0, 0, 1, 0, 0,    0,  4, 0,  1,  5,  32,  7);
        cyc("retire6",       0, 0, 0, 1, 0, 0,    0,  4, 0,  1,  6,  64,  6);
        cyc("comp7",         0, 1, 7, 0, 0, 0,    0,  4, 1,  0,  7,   0,  5);
        cyc("flush5",        1, 1, 0, 1, 1, 0,    0,  4, 0,  1,  7, 255,  5);
        cyc("postFlush5",    0, 0, 0, 0, 0, 0,    0,  0, 0,  0,  0,   0,  0);

        // fill and drain 20 entries with a fixed irregular commitReady pattern
        for (int k = 0; k < 20; k++) begin
            allocQ.push_back(k % N);
            commitQ.push_back(k % N);
        end
        evtOn    = 1'b1;
        granted  = 0;
        retired  = 0;
        cycles   = 0;
        pat      = 16'b1011_0011_1000_1101;
        while (retired < 20 && cycles < 300) begin
            nextPend        = -1;
            allocReq_i      = (granted < 20);
            completeValid_i = (pend.size() > 0);
            completeAddr_i  = (pend.size() > 0) ? AW'(pend.pop_front()) : '0;
            commitReady_i   = pat[cycles % 16];
            flush_i         = 1'b0;
            reset_i         = 1'b0;
            #2;
            if (allocGrant_o) begin
                nextPend = granted % N;
                granted++;
            end
            if (commitValid_o && commitReady_i) retired++;
            @(posedge clk_i);
            #1;
            if (nextPend >= 0) pend.push_back(nextPend);
            cycles++;
        end
        allocReq_i      = 1'b0;
        completeValid_i = 1'b0;
        commitReady_i   = 1'b0;
        cmp("drainRetired", retired, 20);
        cyc("drainEnd",      0, 0, 0, 0, 0, 0,    0,  4, 0,  0,  4,   0,  0);
        evtOn = 1'b0;
        cmp("allocQEmpty",  allocQ.size(), 0);
        cmp("commitQEmpty", commitQ.size(), 0);
        @(posedge clk_i);
        #1;
        cmp("chkQEmpty", chkQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
